// File: rtl/unpacked_pair_alu_pkg.sv
// Shared types and clamp-limit helpers for the pairwise add/subtract engine.
// Limits are built LIM_W wide so callers can slice them to any result width.
package unpacked_pair_alu_pkg;

  typedef enum logic [1:0] {
    WRAP_U = 2'd0,
    WRAP_S = 2'd1,
    SAT_U  = 2'd2,
    SAT_S  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LIM_W = 128;

  // All-ones in the low w bits: the largest unsigned w-bit value.
  function automatic logic [LIM_W-1:0] umax_lim(input int w);
    logic [LIM_W-1:0] v;
    v = '0;
    for (int i = 0; i < LIM_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [LIM_W-1:0] smax_lim(input int w);
    return umax_lim(w - 1);
  endfunction

  // Only bit w-1 set: the most negative w-bit two's-complement pattern.
  function automatic logic [LIM_W-1:0] smin_lim(input int w);
    logic [LIM_W-1:0] v;
    v = '0;
    for (int i = 0; i < LIM_W; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/unpacked_pair_lane.sv
// One pair: x = f(a0 + b0), y = f(a1 - b1) with wrap/saturate per mode; combinational.
// No latency, no flow control; the parent sequences lanes over the operand memories.
module unpacked_pair_lane
  import unpacked_pair_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int OWIDTH = 32
) (
  input  logic [WIDTH-1:0]  a0,
  input  logic [WIDTH-1:0]  b0,
  input  logic [WIDTH-1:0]  a1,
  input  logic [WIDTH-1:0]  b1,
  input  mode_e             mode,
  output logic [OWIDTH-1:0] x,
  output logic [OWIDTH-1:0] y,
  output logic              ovf
);

  // Two guard bits above OWIDTH hold any sum/difference of WIDTH-bit operands exactly.
  localparam int EW = OWIDTH + 2;

  localparam logic [LIM_W-1:0]  UMAX_F = umax_lim(OWIDTH);
  localparam logic [LIM_W-1:0]  SMAX_F = smax_lim(OWIDTH);
  localparam logic [LIM_W-1:0]  SMIN_F = smin_lim(OWIDTH);
  localparam logic [OWIDTH-1:0] UMAX   = UMAX_F[OWIDTH-1:0];
  localparam logic [OWIDTH-1:0] SMAX   = SMAX_F[OWIDTH-1:0];
  localparam logic [OWIDTH-1:0] SMIN   = SMIN_F[OWIDTH-1:0];

  logic          sgn;
  logic          sat;
  logic [EW-1:0] sum;
  logic [EW-1:0] diff;
  logic [OWIDTH:0] fx;
  logic [OWIDTH:0] fy;

  function automatic logic [EW-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
    return {{(EW-WIDTH){s & v[WIDTH-1]}}, v};
  endfunction

  // Returns {out_of_range, result}; result is the wrapped or clamped value.
  function automatic logic [OWIDTH:0] fit(input logic [EW-1:0] v, input logic s,
                                          input logic clamp);
    logic neg;
    logic hi;
    logic lo;
    logic [OWIDTH-1:0] r;
    neg = v[EW-1];
    if (s) begin
      hi = !neg && (v[OWIDTH:OWIDTH-1] != 2'b00);
      lo = neg && (v[OWIDTH:OWIDTH-1] != 2'b11);
    end else begin
      hi = !neg && v[OWIDTH];
      lo = neg;
    end
    r = v[OWIDTH-1:0];
    if (clamp && hi) r = s ? SMAX : UMAX;
    if (clamp && lo) r = s ? SMIN : '0;
    return {hi | lo, r};
  endfunction

  always_comb begin
    sgn  = (mode == WRAP_S) || (mode == SAT_S);
    sat  = (mode == SAT_U) || (mode == SAT_S);
    sum  = ext(a0, sgn) + ext(b0, sgn);
    diff = ext(a1, sgn) - ext(b1, sgn);
    fx   = fit(sum, sgn, sat);
    fy   = fit(diff, sgn, sat);
    x    = fx[OWIDTH-1:0];
    y    = fy[OWIDTH-1:0];
    ovf  = fx[OWIDTH] | fy[OWIDTH];
  end

endmodule

// File: rtl/unpacked_pair_alu.sv
// Pairwise add/subtract over captured operand memories, LANES pairs per cycle; out_valid NB edges after accept.
// Single transaction in flight: in_ready stays low until the result handshake, results hold while out_ready is low.
module unpacked_pair_alu
  import unpacked_pair_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int OWIDTH = 32,
  parameter int LANES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  mem_a    [0:DEPTH-1],
  input  logic [WIDTH-1:0]  mem_b    [0:DEPTH-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] result_x [0:DEPTH/2-1],
  output logic [OWIDTH-1:0] result_y [0:DEPTH/2-1],
  output logic              ovf
);

  localparam int NP = DEPTH / 2;
  localparam int NB = NP / LANES;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NB - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] cap_a [0:DEPTH-1];
  logic [WIDTH-1:0] cap_b [0:DEPTH-1];
  mode_e            mode_q;
  logic [CW-1:0]    k_q;

  logic [WIDTH-1:0]  l_a0 [LANES];
  logic [WIDTH-1:0]  l_b0 [LANES];
  logic [WIDTH-1:0]  l_a1 [LANES];
  logic [WIDTH-1:0]  l_b1 [LANES];
  logic [OWIDTH-1:0] l_x  [LANES];
  logic [OWIDTH-1:0] l_y  [LANES];
  logic [LANES-1:0]  l_ovf;

  // Steer block k of the captured memories onto the lanes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      l_a0[l] = '0;
      l_b0[l] = '0;
      l_a1[l] = '0;
      l_b1[l] = '0;
    end
    for (int kk = 0; kk < NB; kk++) begin
      if (k_q == CW'(kk)) begin
        for (int l = 0; l < LANES; l++) begin
          l_a0[l] = cap_a[2*(kk*LANES+l)];
          l_b0[l] = cap_b[2*(kk*LANES+l)];
          l_a1[l] = cap_a[2*(kk*LANES+l)+1];
          l_b1[l] = cap_b[2*(kk*LANES+l)+1];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    unpacked_pair_lane #(
      .WIDTH  (WIDTH),
      .OWIDTH (OWIDTH)
    ) u_lane (
      .a0   (l_a0[g]),
      .b0   (l_b0[g]),
      .a1   (l_a1[g]),
      .b1   (l_b1[g]),
      .mode (mode_q),
      .x    (l_x[g]),
      .y    (l_y[g]),
      .ovf  (l_ovf[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (k_q == K_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < DEPTH; p++) begin
        cap_a[p] <= '0;
        cap_b[p] <= '0;
      end
      for (int p = 0; p < NP; p++) begin
        result_x[p] <= '0;
        result_y[p] <= '0;
      end
      mode_q <= WRAP_U;
      k_q    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int p = 0; p < DEPTH; p++) begin
              cap_a[p] <= mem_a[p];
              cap_b[p] <= mem_b[p];
            end
            mode_q <= mode_e'(mode);
            k_q    <= '0;
            ovf    <= 1'b0;
          end
        end
        CALC: begin
          // Entries outside block k keep their earlier contents.
          for (int p = 0; p < NP; p++) begin
            if (p / LANES == int'(k_q)) begin
              result_x[p] <= l_x[p % LANES];
              result_y[p] <= l_y[p % LANES];
            end
          end
          ovf <= ovf | (|l_ovf);
          k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
